// File: rtl/axis_rr_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_SRC AXI-Stream sources onto one
// registered AXI-Stream output.
//
// Ports:
//   clk            - single clock, all state on its rising edge
//   reset          - asynchronous active-low reset
//   s_axis_tdata   - NUM_SRC*Data_width, source i at [i*Data_width +: Data_width]
//   s_axis_tvalid  - per-source valid
//   s_axis_tready  - per-source ready (only the granted source can see 1)
//   s_axis_tlast   - per-source end of packet
//   m_axis_tdata   - merged data (registered)
//   m_axis_tvalid  - merged valid (registered)
//   m_axis_tready  - downstream ready
//   m_axis_tlast   - merged end of packet (registered)
//   grant_id       - source owning the output, meaningful while busy=1
//   busy           - high while a packet is being passed through
module axis_rr_arbiter #(
  parameter int unsigned Data_width = 8,
  parameter int unsigned NUM_SRC    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_SRC*Data_width-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]            s_axis_tvalid,
  output logic [NUM_SRC-1:0]            s_axis_tready,
  input  logic [NUM_SRC-1:0]            s_axis_tlast,
  output logic [Data_width-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [2:0]                    grant_id,
  output logic                          busy
);

  typedef enum logic [0:0] {StIdle, StPass} state_e;

  localparam logic [2:0] LastIdx = 3'(NUM_SRC - 1);

  state_e                state_q, state_d;
  logic [2:0]            rr_ptr_q, rr_ptr_d;
  logic [2:0]            grant_q, grant_d;
  logic                  m_valid_q, m_valid_d;
  logic                  m_last_q, m_last_d;
  logic [Data_width-1:0] m_data_q, m_data_d;

  logic                  any_valid;
  logic                  found;
  logic [2:0]            winner;
  int unsigned           idx;
  logic                  sel_valid;
  logic                  sel_last;
  logic [Data_width-1:0] sel_data;
  logic                  out_free;
  logic                  beat;

  assign any_valid = |s_axis_tvalid;

  // First valid source at or above rr_ptr, wrapping past NUM_SRC-1 to 0.
  always_comb begin
    winner = rr_ptr_q;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      idx = (32'(rr_ptr_q) + k) % NUM_SRC;
      if (!found && s_axis_tvalid[idx]) begin
        found  = 1'b1;
        winner = idx[2:0];
      end
    end
  end

  // Mux out the granted source.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (grant_q == 3'(i)) begin
        sel_valid = s_axis_tvalid[i];
        sel_last  = s_axis_tlast[i];
        sel_data  = s_axis_tdata[i*Data_width +: Data_width];
      end
    end
  end

  // The output register can take a new beat when empty or draining this cycle.
  assign out_free = !m_valid_q || m_axis_tready;
  assign beat     = (state_q == StPass) && out_free && sel_valid;

  always_comb begin
    s_axis_tready = '0;
    if ((state_q == StPass) && out_free) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (grant_q == 3'(i)) begin
          s_axis_tready[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    unique case (state_q)
      StIdle: begin
        if (any_valid) begin
          grant_d = winner;
          state_d = StPass;
        end
      end
      StPass: begin
        if (beat && sel_last) begin
          state_d  = StIdle;
          rr_ptr_d = (grant_q == LastIdx) ? 3'd0 : grant_q + 3'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A newly loaded beat wins over clearing on a downstream handshake.
  always_comb begin
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    m_data_d  = m_data_q;
    if (beat) begin
      m_valid_d = 1'b1;
      m_last_d  = sel_last;
      m_data_d  = sel_data;
    end else if (m_valid_q && m_axis_tready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      rr_ptr_q  <= 3'd0;
      grant_q   <= 3'd0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_data_q  <= m_data_d;
    end
  end

  assign m_axis_tdata  = m_data_q;
  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tlast  = m_last_q;
  assign grant_id      = grant_q;
  assign busy          = (state_q == StPass);

endmodule
